// File: rtl/decap_input_arbiter_if.sv
// Stream bundle between the RX queues, the input arbiter and the decap engine.
// The arbiter takes the slave view; the queues and engine side take the master view.
interface decap_input_arbiter_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4
);
  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic [NUM_QUEUES-1:0]                     s_axis_tvalid;
  logic [NUM_QUEUES-1:0]                     s_axis_tlast;
  logic [NUM_QUEUES-1:0]                     s_axis_tready;

  logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser;
  logic                                      m_axis_tvalid;
  logic                                      m_axis_tlast;
  logic                                      m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/decap_input_arbiter.sv
// Packet-locked round-robin arbiter feeding one decap engine from NUM_QUEUES RX queues.
// One idle cycle per packet picks the next queue; the datapath is then a pure mux.
module decap_input_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4,
  parameter int QUEUE_ID_WIDTH     = 3
) (
  input  logic                         axi_aclk,
  input  logic                         reset,
  decap_input_arbiter_if.slave         axis,
  input  logic [NUM_QUEUES-1:0]        queue_enable,
  output logic [QUEUE_ID_WIDTH-1:0]    cur_grant,
  output logic                         busy,
  output logic [NUM_QUEUES*32-1:0]     pkt_count
);
  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int SW    = C_AXIS_DATA_WIDTH / 8;
  localparam int NQ    = NUM_QUEUES;
  localparam int QW    = QUEUE_ID_WIDTH;
  localparam int NSLOT = 1 << QW;

  typedef enum logic {IDLE, PKT} state_t;

  state_t        state_q;
  logic [QW-1:0] rr_ptr_q;
  logic [QW-1:0] grant_q;
  logic          busy_q;

  // Queues are padded out to 2**QW slots so a QW-bit index can address them directly.
  logic [DW-1:0]    tdata_slot [NSLOT];
  logic [SW-1:0]    tstrb_slot [NSLOT];
  logic [UW-1:0]    tuser_slot [NSLOT];
  logic [NSLOT-1:0] tvalid_slot;
  logic [NSLOT-1:0] tlast_slot;
  logic [NSLOT-1:0] elig_slot;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : gen_slot
      if (gi < NQ) begin : g_q
        assign tdata_slot[gi]  = axis.s_axis_tdata[gi*DW +: DW];
        assign tstrb_slot[gi]  = axis.s_axis_tstrb[gi*SW +: SW];
        assign tuser_slot[gi]  = axis.s_axis_tuser[gi*UW +: UW];
        assign tvalid_slot[gi] = axis.s_axis_tvalid[gi];
        assign tlast_slot[gi]  = axis.s_axis_tlast[gi];
        assign elig_slot[gi]   = axis.s_axis_tvalid[gi] & queue_enable[gi];
      end else begin : g_pad
        assign tdata_slot[gi]  = '0;
        assign tstrb_slot[gi]  = '0;
        assign tuser_slot[gi]  = '0;
        assign tvalid_slot[gi] = 1'b0;
        assign tlast_slot[gi]  = 1'b0;
        assign elig_slot[gi]   = 1'b0;
      end
    end
  endgenerate

  // Scan from the farthest offset down so the offset nearest rr_ptr wins.
  logic          sel_found;
  logic [QW-1:0] sel_idx;
  logic [QW:0]   cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (QW+1)'(k);
      if (cand >= (QW+1)'(NQ)) cand = cand - (QW+1)'(NQ);
      if (elig_slot[cand[QW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[QW-1:0];
      end
    end
  end

  logic          in_pkt;
  logic          m_valid;
  logic          m_last;
  logic          pkt_done;
  logic [QW-1:0] rr_next;

  assign in_pkt   = (state_q == PKT);
  assign m_valid  = in_pkt & tvalid_slot[grant_q];
  assign m_last   = in_pkt & tlast_slot[grant_q];
  assign pkt_done = m_valid & axis.m_axis_tready & m_last;
  assign rr_next  = (grant_q == QW'(NQ - 1)) ? '0 : grant_q + QW'(1);

  assign axis.m_axis_tdata  = tdata_slot[grant_q];
  assign axis.m_axis_tstrb  = tstrb_slot[grant_q];
  assign axis.m_axis_tuser  = tuser_slot[grant_q];
  assign axis.m_axis_tvalid = m_valid;
  assign axis.m_axis_tlast  = m_last;

  generate
    for (gi = 0; gi < NQ; gi++) begin : gen_ready
      assign axis.s_axis_tready[gi] = in_pkt & (grant_q == QW'(gi)) & axis.m_axis_tready;
    end
  endgenerate

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            state_q <= PKT;
            busy_q  <= 1'b1;
          end
        end
        PKT: begin
          if (pkt_done) begin
            rr_ptr_q <= rr_next;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign cur_grant = grant_q;

  // Counters only write on increment or reset, so a preloaded value holds until used.
  generate
    for (gi = 0; gi < NQ; gi++) begin : gen_cnt
      logic [31:0] cnt_q;
      logic [31:0] cnt_d;
      assign cnt_d = cnt_q + 32'd1;
      always_ff @(posedge axi_aclk) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (pkt_done && (grant_q == QW'(gi))) begin
          cnt_q <= cnt_d;
        end
      end
      assign pkt_count[gi*32 +: 32] = cnt_q;
    end
  endgenerate
endmodule

// File: tb/tb_decap_input_arbiter.sv
// Bench for decap_input_arbiter: cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_decap_input_arbiter;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  localparam int NQ = 4;
  localparam int QW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decap_input_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(NQ)) axis ();

  logic [NQ-1:0]    queue_enable;
  logic [QW-1:0]    cur_grant;
  logic             busy;
  logic [NQ*32-1:0] pkt_count;

  decap_input_arbiter #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW)
  ) dut (
    .axi_aclk(clk), .reset(rst), .axis(axis), .queue_enable(queue_enable),
    .cur_grant(cur_grant), .busy(busy), .pkt_count(pkt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-queue packet sources.
  int g_len [NQ];
  int g_beat[NQ];
  logic [NQ-1:0] g_on = '0;
  int g_fix = 0;
  int g_prob = 100;
  bit rdy_rand = 0;
  bit rdy_fixed = 1;
  int cyc = 0;
  int done_q[$];
  bit chk_en = 0;
  bit force_pre = 0;

  task automatic drive();
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    for (int i = 0; i < NQ; i++) begin
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW/32; w++) u[w*32 +: 32] = $urandom;
      axis.s_axis_tdata[i*DW +: DW] = d;
      axis.s_axis_tuser[i*UW +: UW] = u;
      axis.s_axis_tstrb[i*SW +: SW] = $urandom;
      axis.s_axis_tvalid[i] = g_on[i] && ($urandom_range(99) < g_prob);
      axis.s_axis_tlast[i]  = (g_beat[i] == g_len[i] - 1);
    end
    axis.m_axis_tready = rdy_rand ? ($urandom_range(99) < 80) : rdy_fixed;
  endtask

  task automatic new_len(input int i);
    g_beat[i] = 0;
    g_len[i]  = (g_fix > 0) ? g_fix : int'($urandom_range(6, 1));
  endtask

  task automatic cycle();
    logic [NQ-1:0] hs;
    @(negedge clk);
    hs = axis.s_axis_tready & axis.s_axis_tvalid;
    if (axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast) done_q.push_back(int'(cur_grant));
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NQ; i++) begin
      if (hs[i]) begin
        if (g_beat[i] == g_len[i] - 1) new_len(i);
        else g_beat[i]++;
      end
    end
    drive();
  endtask

  task automatic restart(input logic [NQ-1:0] on, input int fix);
    rst = 1'b1;
    g_on = '0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    g_fix = fix;
    for (int i = 0; i < NQ; i++) new_len(i);
    g_on = on;
    done_q.delete();
    drive();
  endtask

  // Reference model: one packet owner at a time, round-robin from the queue after the last winner.
  int m_busy = 0;
  int m_grant = 0;
  int m_rr = 0;
  logic [31:0] m_cnt [NQ];

  always @(negedge clk) begin
    logic [NQ-1:0] e_rdy;
    logic e_val;
    int q;
    if (force_pre) m_cnt[3] = 32'hFFFF_FFFF;
    if (chk_en) begin
      e_rdy = '0;
      e_val = 1'b0;
      if (m_busy != 0) begin
        e_val = axis.s_axis_tvalid[m_grant];
        e_rdy[m_grant] = axis.m_axis_tready;
      end
      check("busy", busy, m_busy);
      if (m_busy != 0) check("cur_grant", cur_grant, m_grant);
      check("s_tready", axis.s_axis_tready, e_rdy);
      check("m_tvalid", axis.m_axis_tvalid, e_val);
      if (e_val) begin
        check("m_tlast", axis.m_axis_tlast, axis.s_axis_tlast[m_grant]);
        check("m_tdata", axis.m_axis_tdata, axis.s_axis_tdata[m_grant*DW +: DW]);
        check("m_tstrb", axis.m_axis_tstrb, axis.s_axis_tstrb[m_grant*SW +: SW]);
        check("m_tuser", axis.m_axis_tuser, axis.s_axis_tuser[m_grant*UW +: UW]);
      end
      for (int i = 0; i < NQ; i++) check($sformatf("pkt_count[%0d]", i), pkt_count[i*32 +: 32], m_cnt[i]);
    end
    if (rst) begin
      m_busy = 0; m_grant = 0; m_rr = 0;
      for (int i = 0; i < NQ; i++) m_cnt[i] = '0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < NQ; k++) begin
        q = (m_rr + k) % NQ;
        if (axis.s_axis_tvalid[q] && queue_enable[q]) begin
          m_grant = q;
          m_busy = 1;
          break;
        end
      end
    end else if (axis.s_axis_tvalid[m_grant] && axis.m_axis_tready && axis.s_axis_tlast[m_grant]) begin
      m_cnt[m_grant] = m_cnt[m_grant] + 32'd1;
      m_rr = (m_grant + 1) % NQ;
      m_busy = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int cd;
    rst = 1'b1;
    queue_enable = '1;
    for (int i = 0; i < NQ; i++) new_len(i);

    // Reset state with every queue offering.
    g_on = '1;
    drive();
    cycle();
    cycle();
    check("rst_busy", busy, 0);
    check("rst_cur_grant", cur_grant, 0);
    check("rst_s_tready", axis.s_axis_tready, 0);
    check("rst_m_tvalid", axis.m_axis_tvalid, 0);
    check("rst_pkt_count", pkt_count, 0);
    chk_en = 1'b1;

    // Fairness: 3-beat packets from all queues.
    queue_enable = 4'b1111; g_prob = 100; rdy_rand = 0; rdy_fixed = 1;
    restart(4'b1111, 3);
    c0 = cyc;
    for (int n = 0; n < 400 && done_q.size() < 16; n++) cycle();
    check("fair_npkts", done_q.size(), 16);
    check("fair_cycles", cyc - c0, 64);
    for (int j = 0; j < 16 && j < done_q.size(); j++) check($sformatf("fair_order%0d", j), done_q[j], j % 4);
    for (int i = 0; i < NQ; i++) check($sformatf("fair_cnt%0d", i), pkt_count[i*32 +: 32], 4);

    // Masking: only queues 1 and 3 may win.
    queue_enable = 4'b1010;
    restart(4'b1111, 0);
    for (int n = 0; n < 200 && done_q.size() < 8; n++) cycle();
    check("mask_npkts", done_q.size(), 8);
    for (int j = 0; j < 8 && j < done_q.size(); j++) check($sformatf("mask_order%0d", j), done_q[j], (j % 2 == 0) ? 1 : 3);
    check("mask_cnt0", pkt_count[0 +: 32], 0);
    check("mask_cnt1", pkt_count[32 +: 32], 4);
    check("mask_cnt2", pkt_count[64 +: 32], 0);
    check("mask_cnt3", pkt_count[96 +: 32], 4);

    // Lock under backpressure: queue 2 holds the grant while queue 0 waits.
    queue_enable = 4'b1111;
    restart(4'b0100, 5);
    cycle();
    check("bp_busy", busy, 1);
    check("bp_grant", cur_grant, 2);
    g_on[0] = 1'b1;
    c0 = cyc;
    cd = 0;
    for (int k = 0; k < 30 && done_q.size() < 2; k++) begin
      rdy_fixed = !(k == 1 || k == 2);
      drive();
      #1;
      if (done_q.size() == 0) check("bp_q0_ready", axis.s_axis_tready[0], 0);
      cycle();
      if (done_q.size() >= 1 && cd == 0) cd = cyc;
    end
    rdy_fixed = 1;
    check("bp_npkts", done_q.size(), 2);
    if (done_q.size() >= 2) begin
      check("bp_first", done_q[0], 2);
      check("bp_second", done_q[1], 0);
    end
    check("bp_cycles", cd - c0, 7);
    check("bp_cnt2", pkt_count[64 +: 32], 1);

    // Enable dropped mid-packet: packet finishes, queue never re-granted.
    queue_enable = 4'b1111;
    restart(4'b0010, 4);
    cycle();
    check("en_grant", cur_grant, 1);
    for (int k = 0; k < 25; k++) begin
      if (k == 1) queue_enable[1] = 1'b0;
      drive();
      cycle();
    end
    check("en_npkts", done_q.size(), 1);
    if (done_q.size() >= 1) check("en_first", done_q[0], 1);
    check("en_cnt1", pkt_count[32 +: 32], 1);
    check("en_busy", busy, 0);

    // Reset mid-packet after rr_ptr has moved to 2.
    queue_enable = 4'b1111;
    restart(4'b0010, 1);
    cycle();
    cycle();
    check("rstm_cnt1", pkt_count[32 +: 32], 1);
    g_on = 4'b1000;
    g_fix = 6;
    new_len(3);
    drive();
    cycle();
    check("rstm_grant", cur_grant, 3);
    cycle();
    cycle();
    rst = 1'b1;
    drive();
    cycle();
    check("rstm_busy", busy, 0);
    check("rstm_s_tready", axis.s_axis_tready, 0);
    check("rstm_m_tvalid", axis.m_axis_tvalid, 0);
    check("rstm_pkt_count", pkt_count, 0);
    rst = 1'b0;
    g_on = 4'b1111;
    g_fix = 2;
    for (int i = 0; i < NQ; i++) new_len(i);
    drive();
    cycle();
    check("rstm_rr_busy", busy, 1);
    check("rstm_rr_grant", cur_grant, 0);

    // Counter wrap on a single-beat packet.
    queue_enable = 4'b1111;
    restart(4'b0000, 1);
    force dut.gen_cnt[3].cnt_q = 32'hFFFF_FFFF;
    force_pre = 1'b1;
    cycle();
    release dut.gen_cnt[3].cnt_q;
    force_pre = 1'b0;
    #1;
    check("wrap_preload", pkt_count[96 +: 32], 32'hFFFF_FFFF);
    g_on[3] = 1'b1;
    new_len(3);
    drive();
    c0 = cyc;
    for (int n = 0; n < 10 && pkt_count[96 +: 32] == 32'hFFFF_FFFF; n++) cycle();
    check("wrap_cnt3", pkt_count[96 +: 32], 0);
    check("wrap_cycles", cyc - c0, 2);

    // Randomised traffic: valids, lengths, backpressure, enables and occasional resets.
    restart(4'b1111, 0);
    g_prob = 70;
    rdy_rand = 1;
    for (int n = 0; n < 2000; n++) begin
      if (n % 64 == 0) queue_enable = NQ'($urandom);
      rst = ($urandom_range(299) == 0);
      drive();
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
